// File: rtl/stopwatch_run_sequencer.sv
// Run-control sequencer for the 4-digit stopwatch/timer.
// Turns raw start/lap/clear buttons into single-cycle press events.
// Sequences load/run/pause/lap/done, generates count ticks and the done blink.
module stopwatch_run_sequencer #(
   parameter int TICK_DIV    = 1000000,
   parameter int BLINK_TICKS = 25
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start_btn,
   input  logic        lap_btn,
   input  logic        clear_btn,
   input  logic [1:0]  mode,
   input  logic [3:0]  msb_sw,
   input  logic [3:0]  lsb_sw,
   input  logic        tc_in,
   output logic        load_en,
   output logic [13:0] load_val,
   output logic        count_pulse,
   output logic        count_dir,
   output logic        disp_hold,
   output logic        done,
   output logic        blink,
   output logic [2:0]  state_dbg
);

   localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      ARMED = 3'd2,
      RUN   = 3'd3,
      PAUSE = 3'd4,
      LAP   = 3'd5,
      DONE  = 3'd6
   } state_t;

   state_t          state, state_nxt;
   logic [2:0]      btn_s1, btn_s2, btn_prev;
   logic [2:0]      vld_pipe;
   logic [2:0]      press;
   logic            start_p, lap_p, clear_p;
   logic [PW-1:0]   presc, presc_nxt;
   logic            wrap, running;
   logic [BW-1:0]   bcnt;
   logic            preset_ok;
   logic [13:0]     load_val_nxt;

   // Button synchronizers; vld_pipe marks when btn_prev holds a real
   // post-reset sample, so a button held through reset is not a press.
   always_ff @(posedge clk) begin
      if (!reset) begin
         btn_s1   <= '0;
         btn_s2   <= '0;
         btn_prev <= '0;
         vld_pipe <= '0;
      end else begin
         btn_s1   <= {clear_btn, lap_btn, start_btn};
         btn_s2   <= btn_s1;
         btn_prev <= btn_s2;
         vld_pipe <= {vld_pipe[1:0], 1'b1};
      end
   end

   assign press   = btn_s2 & ~btn_prev & {3{vld_pipe[2]}};
   assign start_p = press[0];
   assign lap_p   = press[1];
   assign clear_p = press[2];

   assign running = (state == RUN) || (state == LAP);
   assign wrap    = (presc == PW'(TICK_DIV - 1));

   // Next state: clear beats terminal count, which beats start, then lap.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_p) state_nxt = LOAD;
         LOAD:    state_nxt = ARMED;
         ARMED:   if (start_p) state_nxt = RUN;
         RUN: begin
            if (tc_in)        state_nxt = DONE;
            else if (start_p) state_nxt = PAUSE;
            else if (lap_p)   state_nxt = LAP;
         end
         PAUSE:   if (start_p) state_nxt = RUN;
         LAP: begin
            if (tc_in)        state_nxt = DONE;
            else if (start_p) state_nxt = PAUSE;
            else if (lap_p)   state_nxt = RUN;
         end
         DONE:    if (start_p) state_nxt = LOAD;
         default: state_nxt = IDLE;
      endcase
      if (clear_p && (state != IDLE)) state_nxt = LOAD;
   end

   // Prescaler: runs while counting and in DONE (blink), holds in PAUSE.
   always_comb begin
      presc_nxt = '0;
      if (running || (state == DONE))
         presc_nxt = wrap ? '0 : presc + PW'(1);
      else if (state == PAUSE)
         presc_nxt = presc;
   end

   // Preset load value; out-of-range switches fall back to the mode default.
   always_comb begin
      preset_ok = mode[0] && (msb_sw <= 4'd9) && (lsb_sw <= 4'd9);
      if (preset_ok)
         load_val_nxt = 14'(msb_sw) * 14'd1000 + 14'(lsb_sw) * 14'd100;
      else
         load_val_nxt = mode[1] ? 14'd9999 : 14'd0;
   end

   // State, prescaler and registered outputs derived from the next state.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= IDLE;
         presc       <= '0;
         load_en     <= 1'b0;
         load_val    <= '0;
         count_dir   <= 1'b0;
         count_pulse <= 1'b0;
         disp_hold   <= 1'b0;
         done        <= 1'b0;
      end else begin
         state       <= state_nxt;
         presc       <= presc_nxt;
         load_en     <= (state_nxt == LOAD);
         disp_hold   <= (state_nxt == LAP);
         done        <= (state_nxt == DONE);
         // terminal count suppresses the tick so the counter never overshoots
         count_pulse <= running && wrap && !tc_in;
         if (state_nxt == LOAD) begin
            load_val  <= load_val_nxt;
            count_dir <= ~mode[1];
         end
      end
   end

   // Done blink: starts high on entry, toggles every BLINK_TICKS wraps.
   always_ff @(posedge clk) begin
      if (!reset) begin
         blink <= 1'b0;
         bcnt  <= '0;
      end else if (state_nxt != DONE) begin
         blink <= 1'b0;
         bcnt  <= '0;
      end else if (state != DONE) begin
         blink <= 1'b1;
         bcnt  <= '0;
      end else if (wrap) begin
         if (bcnt == BW'(BLINK_TICKS - 1)) begin
            bcnt  <= '0;
            blink <= ~blink;
         end else begin
            bcnt <= bcnt + BW'(1);
         end
      end
   end

   assign state_dbg = state;

endmodule
